mem_stall_ctrl: RTL and testbench

Sequencing controller for the MEM stage of the 5-stage pipeline: it watches the control and data outputs of the EX/MEM pipeline register, issues a request/acknowledge transaction to a multi-cycle data memory, and freezes the pipeline until the access completes. It drives the global stall line that holds PC, IF/ID, ID/EX and EX/MEM, and presents load data to MEM/WB in the one cycle the pipeline is allowed to advance. It also detects a hung memory through a timeout, and keeps a performance counter of stall cycles.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/mem_stall_ctrl.sv | 98 +++++++++
 tb/tb_mem_stall_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: MEM-stage controller state encoding and datapath width.
package cpu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } mem_state_t;

endpackage

// File: rtl/sat_counter.sv
// Enable-driven up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage sequencer: issues one request per EX/MEM memory instruction, freezes the
// pipeline until the ack arrives, flags a hung memory and counts stall cycles.
module mem_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] ALU_result_i,
    input  logic [DATA_W-1:0] Write_Data_i,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] Read_Data_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    mem_state_t  state;
    logic [15:0] tmo_cnt;

    // Stall is gated by reset so the pipeline is released the moment reset asserts.
    always_comb begin
        stall_o = 1'b0;
        unique case (state)
            IDLE:    stall_o = MemRead_i | MemWrite_i;
            BUSY:    stall_o = 1'b1;
            DONE:    stall_o = 1'b0;
            ERROR:   stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
        stall_o = stall_o & rst_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            Read_Data_o <= '0;
            err_o       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (MemRead_i || MemWrite_i) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= MemWrite_i;
                        mem_addr_o  <= ALU_result_i;
                        mem_wdata_o <= Write_Data_i;
                        tmo_cnt     <= '0;
                        state       <= BUSY;
                    end
                end
                // tmo_cnt holds the number of BUSY cycles already completed without ack.
                BUSY: begin
                    if (mem_ack_i) begin
                        if (!mem_we_o) begin
                            Read_Data_o <= mem_rdata_i;
                        end
                        mem_req_o <= 1'b0;
                        tmo_cnt   <= '0;
                        state     <= DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        mem_req_o <= 1'b0;
                        err_o     <= 1'b1;
                        state     <= ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                ERROR:   state <= ERROR;
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_n (rst_i),
        .en    (stall_o),
        .count (stall_cnt_o)
    );

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl with a short timeout and a narrow stall counter.
module tb_mem_stall_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] ALU_result_i, Write_Data_i;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] Read_Data_o;
    logic        err_o;
    logic [3:0]  stall_cnt_o;

    int checks = 0;
    int errors = 0;

    mem_stall_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .ALU_result_i (ALU_result_i),
        .Write_Data_i (Write_Data_i),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .Read_Data_o  (Read_Data_o),
        .err_o        (err_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
        ALU_result_i = '0; Write_Data_i = '0; mem_rdata_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({stall_o, mem_req_o, mem_we_o, err_o} !== 4'b0000 || mem_addr_o !== 32'h0 ||
            mem_wdata_o !== 32'h0 || Read_Data_o !== 32'h0 || stall_cnt_o !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_values: stall=%b req=%b we=%b err=%b addr=%h wdata=%h rdata=%h cnt=%h, required all zero",
                     stall_o, mem_req_o, mem_we_o, err_o, mem_addr_o, mem_wdata_o, Read_Data_o, stall_cnt_o);
        end
    endtask

    task automatic test_load();
        MemRead_i = 1'b1; ALU_result_i = 32'h40;
        #1;
        checks++;
        if (stall_o !== 1'b1 || mem_req_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_cycle0: stall=%b req=%b, required stall=1 req=0", stall_o, mem_req_o);
        end
        step();
        checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h40 || stall_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_busy1: req=%b we=%b addr=%h stall=%b, required 1 0 00000040 1",
                     mem_req_o, mem_we_o, mem_addr_o, stall_o);
        end
        step();
        step();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        step();
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        checks++;
        if (stall_o !== 1'b0 || Read_Data_o !== 32'hDEADBEEF || mem_req_o !== 1'b0 || stall_cnt_o !== 4'd4) begin
            errors++;
            $display("[TB] FAIL load_done: stall=%b rdata=%h req=%b cnt=%0d, required 0 deadbeef 0 4",
                     stall_o, Read_Data_o, mem_req_o, stall_cnt_o);
        end
    endtask

    // Continues straight from the load's DONE cycle: the store enters EX/MEM at its end.
    task automatic test_back_to_back();
        MemRead_i = 1'b0; MemWrite_i = 1'b1;
        ALU_result_i = 32'h80; Write_Data_i = 32'h12345678;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_ignores_inputs: stall=%b, required 0", stall_o);
        end
        step();
        checks++;
        if (stall_o !== 1'b1 || mem_req_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle_not_skipped: stall=%b req=%b, required stall=1 req=0", stall_o, mem_req_o);
        end
        step();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hBAADF00D;
        checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h80 ||
            mem_wdata_o !== 32'h12345678 || stall_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL store_busy1: req=%b we=%b addr=%h wdata=%h stall=%b, required 1 1 00000080 12345678 1",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o);
        end
        step();
        mem_ack_i = 1'b0;
        checks++;
        if (stall_o !== 1'b0 || Read_Data_o !== 32'hDEADBEEF || mem_req_o !== 1'b0 || stall_cnt_o !== 4'd6) begin
            errors++;
            $display("[TB] FAIL store_done: stall=%b rdata=%h req=%b cnt=%0d, required 0 deadbeef 0 6",
                     stall_o, Read_Data_o, mem_req_o, stall_cnt_o);
        end
        MemWrite_i = 1'b0;
        step();
        checks++;
        if (stall_o !== 1'b0 || stall_cnt_o !== 4'd6) begin
            errors++;
            $display("[TB] FAIL b2b_idle_after: stall=%b cnt=%0d, required 0 6", stall_o, stall_cnt_o);
        end
    endtask

    task automatic test_read_write_both();
        MemRead_i = 1'b1; MemWrite_i = 1'b1; ALU_result_i = 32'hC4; Write_Data_i = 32'hA5A5A5A5;
        step();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0BADCAFE;
        checks++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== 32'hC4) begin
            errors++;
            $display("[TB] FAIL both_write_wins: we=%b addr=%h, required 1 000000c4", mem_we_o, mem_addr_o);
        end
        step();
        mem_ack_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        checks++;
        if (Read_Data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL both_rdata_kept: rdata=%h, required deadbeef", Read_Data_o);
        end
        step();
    endtask

    task automatic test_ack_at_timeout();
        do_reset();
        MemRead_i = 1'b1; ALU_result_i = 32'h10;
        step();
        step();
        step();
        step();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h00C0FFEE;
        step();
        mem_ack_i = 1'b0; MemRead_i = 1'b0;
        checks++;
        if (stall_o !== 1'b0 || err_o !== 1'b0 || Read_Data_o !== 32'h00C0FFEE || stall_cnt_o !== 4'd5) begin
            errors++;
            $display("[TB] FAIL ack_at_timeout: stall=%b err=%b rdata=%h cnt=%0d, required 0 0 00c0ffee 5",
                     stall_o, err_o, Read_Data_o, stall_cnt_o);
        end
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        MemRead_i = 1'b1; ALU_result_i = 32'h20;
        step();
        step();
        step();
        step();
        checks++;
        if (mem_req_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_busy4: req=%b err=%b, required 1 0", mem_req_o, err_o);
        end
        step();
        checks++;
        if (err_o !== 1'b1 || stall_o !== 1'b1 || mem_req_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_error: err=%b stall=%b req=%b, required 1 1 0", err_o, stall_o, mem_req_o);
        end
        MemRead_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111;
        step();
        mem_ack_i = 1'b0;
        checks++;
        if (err_o !== 1'b1 || stall_o !== 1'b1 || mem_req_o !== 1'b0 || Read_Data_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL error_ignores_ack: err=%b stall=%b req=%b rdata=%h, required 1 1 0 00000000",
                     err_o, stall_o, mem_req_o, Read_Data_o);
        end
        repeat (14) step();
        checks++;
        if (stall_cnt_o !== 4'hF) begin
            errors++;
            $display("[TB] FAIL cnt_saturate: cnt=%h, required f", stall_cnt_o);
        end
        do_reset();
        checks++;
        if (err_o !== 1'b0 || stall_o !== 1'b0 || stall_cnt_o !== 4'h0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL error_reset: err=%b stall=%b cnt=%h req=%b, required all zero",
                     err_o, stall_o, stall_cnt_o, mem_req_o);
        end
    endtask

    task automatic test_reset_mid_busy();
        MemWrite_i = 1'b1; ALU_result_i = 32'h90; Write_Data_i = 32'h55;
        step();
        step();
        checks++;
        if (mem_req_o !== 1'b1 || stall_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_busy_pre: req=%b stall=%b, required 1 1", mem_req_o, stall_o);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || mem_addr_o !== 32'h0 || stall_cnt_o !== 4'h0) begin
            errors++;
            $display("[TB] FAIL mid_busy_async: req=%b stall=%b addr=%h cnt=%h, required 0 0 0 0",
                     mem_req_o, stall_o, mem_addr_o, stall_cnt_o);
        end
        MemWrite_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        step();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h77777777;
        step();
        mem_ack_i = 1'b0;
        checks++;
        if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || Read_Data_o !== 32'h0 || stall_cnt_o !== 4'h0) begin
            errors++;
            $display("[TB] FAIL spurious_ack_idle: stall=%b req=%b rdata=%h cnt=%h, required 0 0 0 0",
                     stall_o, mem_req_o, Read_Data_o, stall_cnt_o);
        end
        step();
        checks++;
        if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spurious_ack_after: stall=%b req=%b, required 0 0", stall_o, mem_req_o);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_read_write_both();
        test_ack_at_timeout();
        test_timeout();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
